ecc_enc_dec_core: RTL and testbench
===================================

// Module: ecc_enc_dec_core
// PURPOSE
//  ECC datapath fed by the APB register bank: consumes CTRL, DATA_IN, CODEWORD_WIDTH, NOISE.
//  Performs extended-Hamming (SECDED) encode, decode, or full channel (encode, XOR noise, decode).
//  Result returns to the bus side via data_out/num_of_errors; one operation in flight.
// PARAMETERS
//  AMBA_WORD   32  width of data_in, noise, data_out
// PORTS
//  clk             in   1          single clock, rising edge
//  rst             in   1          asynchronous, active-low reset
//  start           in   1          1-cycle pulse from register bank on CTRL write
//  ctrl            in   2          00 encode, 01 decode, 10 full channel, 11 reserved
//  data_in         in   AMBA_WORD  data (encode/full) or received codeword (decode)
//  codeword_width  in   2          00 N=8 (K=4), 01 N=16 (K=11), 10 N=32 (K=26), 11 treated as 10
//  noise           in   AMBA_WORD  XOR mask applied to codeword in full-channel mode only
//  busy            out  1          high from the cycle after accepted start until the DONE cycle
//  operation_done  out  1          1-cycle pulse; data_out/num_of_errors valid in that cycle
//  data_out        out  AMBA_WORD  codeword (encode) or K data bits zero-extended (decode/full)
//  num_of_errors   out  2          00 none, 01 single (corrected), 10 double/uncorrectable; 00 for encode
// BEHAVIOUR
//  Reset (rst=0, any time incl. mid-op): state IDLE, busy=0, operation_done=0, data_out=0, num_of_errors=0.
//  FSM: IDLE -> ENC | DEC -> (full: ENC -> DEC) -> DONE -> IDLE.
//   - IDLE: start=1 snapshots ctrl/data_in/width/noise into regs. Go to ENC (00, 10) or DEC (01).
//   - start with ctrl=11: go straight to DONE, data_out=0, errors=00.
//   - ENC: register codeword. Next state DONE (00), or DEC with noise applied to codeword (10).
//   - DEC: register corrected data + error count; next state DONE.
//   - DONE: operation_done=1, data_out/num_of_errors driven from result regs (held until next DONE).
//  Latency (start sampled at edge T): done high after edge T+2 for encode/decode, T+3 for full, T+1 for reserved.
//  start while busy or in DONE is ignored (no queueing); snapshot regs stay unchanged.
//  Code layout (P = N-K parity bits):
//   - Data bit i sits at Hamming position h(i) = i-th integer >=3 that is not a power of 2.
//   - Check c[j], j=0..P-2: XOR of data bits whose h(i) has bit j set.
//   - Overall parity bit: XOR of all data and check bits.
//   - Codeword = {overall, c[P-2:0], d[K-1:0]}, zero-extended to AMBA_WORD.
//  Input masking: bits >= N of data_in are ignored in decode; bits >= K in encode.
//   Noise bits >= N are ignored.
//  Decode rules: s = recomputed c XOR received c; p = XOR over all N received bits.
//   - s=0, p=0: errors 00, data as received.
//   - p=1, s=0: overall bit flipped; errors 01, data unchanged.
//   - p=1, s power of 2: check bit flipped; errors 01, data unchanged.
//   - p=1, s=h(i): flip d[i]; errors 01.
//   - p=1, s not a valid position <N: errors 10, data uncorrected.
//   - p=0, s!=0: errors 10, data uncorrected.
// STRUCTURE
//  ecc_pkg:
//   - enums ctrl_e {ENCODE, DECODE, FULL, RSVD}, width_e.
//   - N/K/P constants per width.
//   - function hpos(i) returning Hamming position.
//  Sub-module ecc_parity_gen (combinational: width, K data bits -> P-1 checks + overall).
//   Shared by the ENC and DEC paths; one instance.
//  FSM, snapshot regs and result regs live in this module.
// TESTING
//  - Encode N=8, data_in=0x0B -> 0x1B after 3 cycles, errors 00, one-cycle operation_done.
//  - Decode N=8, data_in=0x1B -> data_out=0x0B, errors 00.
//    Decode 0x19 (d1 flipped, s=5) -> 0x0B, errors 01.
//  - Full N=8, data 0x0B: noise 0x02 -> 0x0B, errors 01, done 4 cycles after start.
//    Noise 0x03 -> data_out=0x08, errors 10. Noise 0x80 -> 0x0B, errors 01.
//  - N=32 encode/decode round trip of 0x3FFFFFF and 0x0000001, each with single-bit noise
//    swept over all 32 positions -> original data, errors 01.
//  - start pulse while busy with different data_in -> first result unchanged, no second done.
//    ctrl=11 -> done after 2 cycles, data_out=0.
//  - rst low mid full-channel op -> all outputs 0 immediately, no done.
//    New start after release completes normally.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared types, code-size constants and Hamming-layout helpers for the SECDED core.
package ecc_pkg;

  localparam int unsigned KMAX = 26;  // widest data field (N=32)
  localparam int unsigned CMAX = 5;   // widest check field, excluding the overall bit

  localparam int unsigned N8  = 8;
  localparam int unsigned K8  = 4;
  localparam int unsigned P8  = 4;
  localparam int unsigned N16 = 16;
  localparam int unsigned K16 = 11;
  localparam int unsigned P16 = 5;
  localparam int unsigned N32 = 32;
  localparam int unsigned K32 = 26;
  localparam int unsigned P32 = 6;

  typedef enum logic [1:0] {
    ENCODE = 2'b00,
    DECODE = 2'b01,
    FULL   = 2'b10,
    RSVD   = 2'b11
  } ctrl_e;

  typedef enum logic [1:0] {
    W8      = 2'b00,
    W16     = 2'b01,
    W32     = 2'b10,
    W32_ALT = 2'b11
  } width_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ENC  = 2'b01,
    S_DEC  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // Hamming position of data bit i: i-th integer >= 3 that is not a power of two.
  function automatic int unsigned hpos(input int unsigned i);
    int unsigned r;
    int unsigned n;
    r = 0;
    n = 0;
    for (int unsigned p = 3; p < 64; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == i) r = p;
        n++;
      end
    end
    return r;
  endfunction

  // Data bits covered by check bit j.
  function automatic logic [KMAX-1:0] hmask(input int unsigned j);
    logic [KMAX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < KMAX; i++) begin
      m[i] = ((hpos(i) >> j) & 32'd1) != 32'd0;
    end
    return m;
  endfunction

  // Codeword bits that exist for a given width.
  function automatic logic [31:0] mask_n(input width_e w);
    logic [31:0] m;
    case (w)
      W8:      m = 32'((64'd1 << N8) - 64'd1);
      W16:     m = 32'((64'd1 << N16) - 64'd1);
      default: m = 32'((64'd1 << N32) - 64'd1);
    endcase
    return m;
  endfunction

  // Data bits that exist for a given width.
  function automatic logic [KMAX-1:0] mask_k(input width_e w);
    logic [KMAX-1:0] m;
    case (w)
      W8:      m = KMAX'((64'd1 << K8) - 64'd1);
      W16:     m = KMAX'((64'd1 << K16) - 64'd1);
      default: m = KMAX'((64'd1 << K32) - 64'd1);
    endcase
    return m;
  endfunction

  // Check bits (excluding overall parity) that exist for a given width.
  function automatic logic [CMAX-1:0] mask_c(input width_e w);
    logic [CMAX-1:0] m;
    case (w)
      W8:      m = CMAX'((64'd1 << (P8 - 1)) - 64'd1);
      W16:     m = CMAX'((64'd1 << (P16 - 1)) - 64'd1);
      default: m = CMAX'((64'd1 << (P32 - 1)) - 64'd1);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ecc_parity_gen.sv
// Combinational check-bit and overall-parity generator shared by encode and decode.
module ecc_parity_gen
  import ecc_pkg::*;
(
  input  width_e          i_width,
  input  logic [KMAX-1:0] i_data,
  output logic [CMAX-1:0] o_check_c,
  output logic            o_overall_c
);

  logic [CMAX-1:0] w_chk_raw;

  // Each check bit is the XOR of the data bits whose position has that bit set.
  for (genvar j = 0; j < CMAX; j++) begin : g_chk
    localparam logic [KMAX-1:0] HMASK = hmask(j);
    assign w_chk_raw[j] = ^(i_data & HMASK);
  end

  assign o_check_c   = w_chk_raw & mask_c(i_width);
  assign o_overall_c = (^i_data) ^ (^o_check_c);

endmodule

// File: rtl/ecc_enc_dec_core.sv
// SECDED encode / decode / full-channel engine, one operation in flight.
module ecc_enc_dec_core
  import ecc_pkg::*;
#(
  parameter int unsigned AMBA_WORD = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           ctrl,
  input  logic [AMBA_WORD-1:0] data_in,
  input  logic [1:0]           codeword_width,
  input  logic [AMBA_WORD-1:0] noise,
  output logic                 busy,
  output logic                 operation_done,
  output logic [AMBA_WORD-1:0] data_out,
  output logic [1:0]           num_of_errors
);

  state_e               r_state;
  state_e               w_state_nxt;

  ctrl_e                r_ctrl;
  width_e               r_width;
  logic [AMBA_WORD-1:0] r_data;
  logic [AMBA_WORD-1:0] r_noise;
  logic [AMBA_WORD-1:0] r_cw;
  logic [AMBA_WORD-1:0] r_res_data;
  logic [1:0]           r_res_err;

  logic                 r_busy;
  logic                 r_done;
  logic [AMBA_WORD-1:0] r_data_out;
  logic [1:0]           r_nerr;

  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic [AMBA_WORD-1:0] w_dout_nxt;
  logic [1:0]           w_nerr_nxt;

  logic                 w_accept;
  logic [AMBA_WORD-1:0] w_mask_n;
  logic [KMAX-1:0]      w_mask_k;
  logic [AMBA_WORD-1:0] w_rx;
  logic [KMAX-1:0]      w_rx_d;
  logic [CMAX-1:0]      w_rx_c;
  logic [KMAX-1:0]      w_gen_d;
  logic [CMAX-1:0]      w_chk;
  logic                 w_ovr;
  logic [AMBA_WORD-1:0] w_cw;
  logic [CMAX-1:0]      w_syn;
  logic                 w_par;
  logic                 w_syn_pow2;
  logic [KMAX-1:0]      w_hit;
  logic [AMBA_WORD-1:0] w_dec_data;
  logic [1:0]           w_dec_err;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_mask_n = AMBA_WORD'(mask_n(r_width));
  assign w_mask_k = mask_k(r_width);

  // Decode mode reads the snapshot directly; full channel reads the noisy codeword.
  assign w_rx = (r_ctrl == DECODE) ? (r_data & w_mask_n) : r_cw;

  // Split the received word into its data and check fields.
  always_comb begin
    w_rx_d = '0;
    w_rx_c = '0;
    case (r_width)
      W8: begin
        w_rx_d = KMAX'(w_rx[3:0]);
        w_rx_c = CMAX'(w_rx[6:4]);
      end
      W16: begin
        w_rx_d = KMAX'(w_rx[10:0]);
        w_rx_c = CMAX'(w_rx[14:11]);
      end
      default: begin
        w_rx_d = w_rx[25:0];
        w_rx_c = w_rx[30:26];
      end
    endcase
  end

  // One generator: fed the snapshot data when encoding, the received data when decoding.
  assign w_gen_d = (r_state == S_DEC) ? w_rx_d : (r_data[KMAX-1:0] & w_mask_k);

  ecc_parity_gen u_parity (
    .i_width     (r_width),
    .i_data      (w_gen_d),
    .o_check_c   (w_chk),
    .o_overall_c (w_ovr)
  );

  // Assemble {overall, checks, data} for the selected width.
  always_comb begin
    w_cw = '0;
    case (r_width)
      W8:      w_cw = AMBA_WORD'({w_ovr, w_chk[2:0], w_gen_d[3:0]});
      W16:     w_cw = AMBA_WORD'({w_ovr, w_chk[3:0], w_gen_d[10:0]});
      default: w_cw = AMBA_WORD'({w_ovr, w_chk[4:0], w_gen_d[25:0]});
    endcase
  end

  assign w_syn      = w_chk ^ w_rx_c;
  assign w_par      = ^w_rx;
  assign w_syn_pow2 = (w_syn != '0) && ((w_syn & (w_syn - CMAX'(1))) == '0);

  // Data bit whose position matches the syndrome, limited to bits present at this width.
  for (genvar i = 0; i < KMAX; i++) begin : g_hit
    localparam int unsigned HP = hpos(i);
    assign w_hit[i] = (w_syn == CMAX'(HP)) && w_mask_k[i];
  end

  // SECDED classification and single-bit correction.
  always_comb begin
    w_dec_data = AMBA_WORD'(w_rx_d);
    w_dec_err  = 2'b00;
    if (w_par) begin
      if ((w_syn == '0) || w_syn_pow2) begin
        w_dec_err = 2'b01;
      end else if (|w_hit) begin
        w_dec_data = AMBA_WORD'(w_rx_d ^ w_hit);
        w_dec_err  = 2'b01;
      end else begin
        w_dec_err = 2'b10;
      end
    end else if (w_syn != '0) begin
      w_dec_err = 2'b10;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_dout_nxt  = r_data_out;
    w_nerr_nxt  = r_nerr;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (ctrl_e'(ctrl))
            ENCODE, FULL: w_state_nxt = S_ENC;
            DECODE:       w_state_nxt = S_DEC;
            default:      w_state_nxt = S_DONE;
          endcase
        end
      end
      S_ENC:   w_state_nxt = (r_ctrl == FULL) ? S_DEC : S_DONE;
      S_DEC:   w_state_nxt = S_DONE;
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
        w_dout_nxt  = r_res_data;
        w_nerr_nxt  = r_res_err;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and registered bus-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_data_out <= '0;
      r_nerr     <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_data_out <= w_dout_nxt;
      r_nerr     <= w_nerr_nxt;
    end
  end

  // Snapshot on accepted start, codeword in ENC, decode result in DEC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl     <= ENCODE;
      r_width    <= W8;
      r_data     <= '0;
      r_noise    <= '0;
      r_cw       <= '0;
      r_res_data <= '0;
      r_res_err  <= 2'b00;
    end else begin
      if (w_accept) begin
        r_ctrl     <= ctrl_e'(ctrl);
        r_width    <= (codeword_width == 2'b11) ? W32 : width_e'(codeword_width);
        r_data     <= data_in;
        r_noise    <= noise;
        r_res_data <= '0;
        r_res_err  <= 2'b00;
      end
      if (r_state == S_ENC) begin
        r_cw       <= w_cw ^ ((r_ctrl == FULL) ? (r_noise & w_mask_n) : '0);
        r_res_data <= w_cw;
        r_res_err  <= 2'b00;
      end
      if (r_state == S_DEC) begin
        r_res_data <= w_dec_data;
        r_res_err  <= w_dec_err;
      end
    end
  end

  assign busy           = r_busy;
  assign operation_done = r_done;
  assign data_out       = r_data_out;
  assign num_of_errors  = r_nerr;

endmodule

// File: tb/tb_ecc_enc_dec_core.sv
// Scoreboard bench for ecc_enc_dec_core: driver queues expectations, monitor checks on operation_done.
module tb_ecc_enc_dec_core;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  ctrl;
  logic [31:0] data_in;
  logic [1:0]  codeword_width;
  logic [31:0] noise;
  logic        busy;
  logic        operation_done;
  logic [31:0] data_out;
  logic [1:0]  num_of_errors;

  ecc_enc_dec_core #(.AMBA_WORD(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .ctrl           (ctrl),
    .data_in        (data_in),
    .codeword_width (codeword_width),
    .noise          (noise),
    .busy           (busy),
    .operation_done (operation_done),
    .data_out       (data_out),
    .num_of_errors  (num_of_errors)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  e;
  } exp_t;

  exp_t  q[$];
  exp_t  m_e;
  string cur_name = "none";
  int    n_tests = 0;
  int    n_fail = 0;
  int    n_done = 0;
  int    n_exp_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && operation_done) begin
      n_done++;
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s.unexpected_done: actual data 0x%08h required no done", cur_name, data_out);
      end else begin
        m_e = q.pop_front();
        chk({cur_name, ".data_out"}, data_out, m_e.d);
        chk({cur_name, ".errors"}, 32'(num_of_errors), 32'(m_e.e));
      end
    end
  end

  task automatic push_exp(input logic [31:0] ed, input logic [1:0] ee);
    exp_t x;
    x.d = ed;
    x.e = ee;
    q.push_back(x);
    n_exp_done++;
  endtask

  // Issue one operation from a negedge, wait (bounded) for done and check its latency.
  task automatic run_op(input string name, input logic [1:0] c, input logic [1:0] w,
                        input logic [31:0] d, input logic [31:0] nz,
                        input logic [31:0] ed, input logic [1:0] ee, input int lat_exp);
    int lat;
    cur_name = name;
    push_exp(ed, ee);
    ctrl = c;
    codeword_width = w;
    data_in = d;
    noise = nz;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!operation_done && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk({name, ".latency"}, 32'(lat), 32'(lat_exp));
    @(negedge clk);
    chk({name, ".done_pulse"}, 32'(operation_done), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    ctrl = 2'b00;
    codeword_width = 2'b00;
    data_in = '0;
    noise = '0;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(operation_done), 32'd0);
    chk("reset.data_out", data_out, 32'd0);
    chk("reset.errors", 32'(num_of_errors), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_op("enc8",       2'b00, 2'b00, 32'h0000_000B, 32'h0,          32'h0000_001B, 2'b00, 3);
    run_op("enc8_mask",  2'b00, 2'b00, 32'hFFFF_FF0B, 32'h0,          32'h0000_001B, 2'b00, 3);
    run_op("dec8",       2'b01, 2'b00, 32'h0000_001B, 32'h0,          32'h0000_000B, 2'b00, 3);
    run_op("dec8_d1",    2'b01, 2'b00, 32'h0000_0019, 32'h0,          32'h0000_000B, 2'b01, 3);
    run_op("dec8_chk",   2'b01, 2'b00, 32'h0000_000B, 32'h0,          32'h0000_000B, 2'b01, 3);
    run_op("dec8_mask",  2'b01, 2'b00, 32'hABCD_EF1B, 32'h0,          32'h0000_000B, 2'b00, 3);
    run_op("full8_n02",  2'b10, 2'b00, 32'h0000_000B, 32'h0000_0002, 32'h0000_000B, 2'b01, 4);
    run_op("full8_n03",  2'b10, 2'b00, 32'h0000_000B, 32'h0000_0003, 32'h0000_0008, 2'b10, 4);
    run_op("full8_n80",  2'b10, 2'b00, 32'h0000_000B, 32'h0000_0080, 32'h0000_000B, 2'b01, 4);
    run_op("full8_nhi",  2'b10, 2'b00, 32'h0000_000B, 32'hFFFF_FF00, 32'h0000_000B, 2'b00, 4);
    run_op("enc16",      2'b00, 2'b01, 32'h0000_07FF, 32'h0,          32'h0000_FFFF, 2'b00, 3);
    run_op("dec16_d0",   2'b01, 2'b01, 32'h0000_FFFE, 32'h0,          32'h0000_07FF, 2'b01, 3);
    run_op("enc32_ones", 2'b00, 2'b10, 32'h03FF_FFFF, 32'h0,          32'hFFFF_FFFF, 2'b00, 3);
    run_op("enc32_one",  2'b00, 2'b10, 32'h0000_0001, 32'h0,          32'h8C00_0001, 2'b00, 3);
    run_op("enc_w11",    2'b00, 2'b11, 32'h0000_0001, 32'h0,          32'h8C00_0001, 2'b00, 3);
    run_op("dec32_ones", 2'b01, 2'b10, 32'hFFFF_FFFF, 32'h0,          32'h03FF_FFFF, 2'b00, 3);
    run_op("dec32_one",  2'b01, 2'b10, 32'h8C00_0001, 32'h0,          32'h0000_0001, 2'b00, 3);

    for (int b = 0; b < 32; b++) begin
      run_op($sformatf("sweep_ones_b%0d", b), 2'b10, 2'b10, 32'h03FF_FFFF, 32'h1 << b,
             32'h03FF_FFFF, 2'b01, 4);
      run_op($sformatf("sweep_one_b%0d", b), 2'b10, 2'b10, 32'h0000_0001, 32'h1 << b,
             32'h0000_0001, 2'b01, 4);
    end

    run_op("rsvd", 2'b11, 2'b00, 32'hDEAD_BEEF, 32'h0, 32'h0, 2'b00, 2);

    // start held high through ENC and DONE with different data: must be ignored
    cur_name = "busy_start";
    push_exp(32'h0000_001B, 2'b00);
    ctrl = 2'b00;
    codeword_width = 2'b00;
    data_in = 32'h0000_000B;
    noise = '0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("busy_start.busy", 32'(busy), 32'd1);
    data_in = 32'h0000_0005;
    ctrl = 2'b01;
    @(posedge clk);
    @(negedge clk);
    chk("busy_start.no_early_done", 32'(operation_done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("busy_start.done", 32'(operation_done), 32'd1);
    start = 1'b0;
    repeat (6) @(negedge clk);

    // reset in the middle of a full-channel op
    cur_name = "rst_mid";
    ctrl = 2'b10;
    codeword_width = 2'b00;
    data_in = 32'h0000_000B;
    noise = 32'h0000_0002;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid.busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid.busy", 32'(busy), 32'd0);
    chk("rst_mid.done", 32'(operation_done), 32'd0);
    chk("rst_mid.data_out", data_out, 32'd0);
    chk("rst_mid.errors", 32'(num_of_errors), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_mid.no_done", 32'(operation_done), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    run_op("after_rst", 2'b10, 2'b00, 32'h0000_000B, 32'h0000_0002, 32'h0000_000B, 2'b01, 4);

    repeat (4) @(negedge clk);
    chk("done_count", 32'(n_done), 32'(n_exp_done));
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
